iqdemap_multi: RTL
==================

Name: iqdemap_multi

Overview:
Parametrised successor to the fixed QPSK demapper: hard-decision IQ demapper supporting BPSK, QPSK and 16-QAM.
- Slices each valid (I,Q) sample into 1, 2 or 4 raw bits and emits them per symbol on raw/valid_raw.
- Packs the bits MSB-first into a WORD_W output word for the downstream writer.
- Adds an explicit flush, which emits a zero-padded partial word and reports its fill count.
- Sits between the equaliser output and the frame writer in the receive chain.

Parameters:
IQ_W, 11, signed width of I and Q samples.
WORD_W, 128, packed output word width; must be a multiple of 4.
QAM_THR, 683, 16-QAM inner/outer decision magnitude (nominal levels ±342/±1023).
CNT_W, $clog2(WORD_W+1), width of fill counter and fill_bits.

Ports:
ck  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low.
ce  in  1  clock enable.
mode  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as QPSK).
valid_i  in  1  sample strobe.
ar  in  IQ_W  signed I sample.
ai  in  IQ_W  signed Q sample.
flush  in  1  emit the current partial word.
valid_raw  out  1  one-cycle strobe: raw holds the current symbol's bits.
raw  out  4  symbol bits, right-aligned (BPSK in raw[0], QPSK in raw[1:0]).
valid_o  out  1  one-cycle strobe: writer_data is a complete or flushed word.
writer_data  out  WORD_W  packed word; first symbol occupies the MSBs.
fill_bits  out  CNT_W  number of valid bits in writer_data; WORD_W on a full word.
mode_o  out  2  mode used for the word on writer_data.

Behaviour:
- Reset (rst=0 at a ck edge, overrides ce): all outputs 0; fill counter 0; shift register 0; latched mode 0.
- ce=0: valid_raw and valid_o register to 0; all other state holds; valid_i and flush are ignored.
- Slicing, per axis x:
  - s = 1 if x<0.
  - 16-QAM inner bit n = 1 if -QAM_THR <= x < QAM_THR.
  - BPSK: raw = {3'b0, sI}.
  - QPSK: raw = {2'b0, sI, sQ}.
  - 16-QAM: raw = {sI, nI, sQ, nQ}.
  - Compare in IQ_W+1 bits; -2^(IQ_W-1) is an outer point.
- Latency: valid_i at edge k gives valid_raw/raw at edge k+1 (registered). raw holds its value between strobes.
- Mode latching: mode is sampled when a valid_i arrives with the fill counter at 0. mode changes mid-word are ignored until the word is emitted or flushed.
- Packing: bits per symbol B = 1, 2 or 4. The shift register shifts left by B and appends the bits; the counter adds B.
- Full word: when counter+B == WORD_W, writer_data, fill_bits=WORD_W, mode_o and valid_o register at the same edge as that symbol's valid_raw. The counter returns to 0, and the next valid_i starts a new word with no gap cycle.
- Flush:
  - With counter>0 and no valid_i: at the next edge emit {bits, zero padding} left-aligned, fill_bits=counter, valid_o=1; counter clears.
  - flush with valid_i in the same cycle: the symbol is included first, then the padded word is emitted; if that completes a full word, it is a normal full emission.
  - flush with counter 0 and no valid_i: no-op, valid_o stays 0.
- writer_data, fill_bits and mode_o hold until the next emission.
- Reset mid-word discards the partial word; no valid_o is generated.
- Reserved mode 3 behaves exactly as QPSK, and mode_o reports 3.

Decomposition:
- Shared include iqdemap_defs.vh: mode encodings MODE_BPSK/MODE_QPSK/MODE_QAM16/MODE_RSVD and the bits-per-mode function.
- One combinational sub-module, iqdemap_slicer (ar, ai, mode → raw[3:0]), reused by later soft-decision variants.
- Packer, counter and flush control stay in iqdemap_multi.

Test Plan:
- QPSK, 64 consecutive samples (1023,-1024) → raw=4'b0001 each cycle; one valid_o with writer_data={64{2'b01}}, fill_bits=128, mode_o=1; valid_o 1 cycle after the 64th valid_i.
- 16-QAM, 32 samples (342,-1024) → raw=4'b0110; writer_data={32{4'b0110}}. Then (-1024,-342) gives raw=4'b1011. Check boundaries x=682 (inner), x=683 (outer), x=-683 (inner), x=-684 (outer).
- BPSK, 128 samples alternating ar=1023/-1024 → writer_data={64{2'b01}}. A mode change to QPSK asserted mid-word has no effect until the word is emitted.
- QPSK, 10 samples (-1024,1023) then flush → writer_data[127:108]={10{2'b10}}, remainder 0, fill_bits=20. A second flush with an empty counter gives no valid_o.
- ce toggled low every other cycle during a QPSK word → word identical to the ce=1 result; valid pulses never exceed 1 cycle. Reset after 30 symbols, then 64 symbols → only one valid_o, containing the post-reset data only.
- Flush and valid_i coincide on the 64th QPSK symbol → single full word, fill_bits=128, no extra empty emission.

Source files
------------

// File: rtl/iqdemap_multi_pkg.sv
// Shared definitions for the multi-mode IQ demapper: mode encodings and
// the bits-per-symbol mapping used by both the slicer and the packer.
package iqdemap_multi_pkg;

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Number of raw bits produced per symbol; reserved mode runs as QPSK.
  function automatic logic [2:0] bits_per_mode(input logic [1:0] m);
    logic [2:0] b;
    case (m)
      MODE_BPSK:  b = 3'd1;
      MODE_QPSK:  b = 3'd2;
      MODE_QAM16: b = 3'd4;
      default:    b = 3'd2;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iqdemap_multi_slicer.sv
// Combinational hard-decision slicer: maps one (I,Q) sample to up to four
// raw bits, right-aligned, according to the modulation mode.
module iqdemap_slicer
  import iqdemap_multi_pkg::*;
#(
  parameter int IQ_W    = 11,
  parameter int QAM_THR = 683
) (
  input  logic signed [IQ_W-1:0] ar,
  input  logic signed [IQ_W-1:0] ai,
  input  logic        [1:0]      mode,
  output logic        [3:0]      raw
);

  // Comparisons are done one bit wider so the threshold and its negation
  // are both representable and the most negative input stays an outer point.
  localparam logic signed [IQ_W:0] THR_P = (IQ_W + 1)'(QAM_THR);
  localparam logic signed [IQ_W:0] THR_N = -THR_P;

  logic signed [IQ_W:0] ar_x_s;
  logic signed [IQ_W:0] ai_x_s;
  logic                 si_s;
  logic                 sq_s;
  logic                 ni_s;
  logic                 nq_s;

  // Sign and inner-ring decisions per axis, then assemble bits by mode.
  always_comb begin
    ar_x_s = {ar[IQ_W-1], ar};
    ai_x_s = {ai[IQ_W-1], ai};
    si_s   = ar_x_s[IQ_W];
    sq_s   = ai_x_s[IQ_W];
    ni_s   = (ar_x_s >= THR_N) && (ar_x_s < THR_P);
    nq_s   = (ai_x_s >= THR_N) && (ai_x_s < THR_P);
    case (mode)
      MODE_BPSK:  raw = {3'b000, si_s};
      MODE_QAM16: raw = {si_s, ni_s, sq_s, nq_s};
      default:    raw = {2'b00, si_s, sq_s};
    endcase
  end

endmodule

// File: rtl/iqdemap_multi.sv
// Multi-mode hard-decision IQ demapper with MSB-first word packer and
// explicit flush of partial words.
module iqdemap_multi
  import iqdemap_multi_pkg::*;
#(
  parameter int IQ_W    = 11,
  parameter int WORD_W  = 128,
  parameter int QAM_THR = 683,
  parameter int CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [1:0]             mode,
  input  logic                   valid_i,
  input  logic signed [IQ_W-1:0] ar,
  input  logic signed [IQ_W-1:0] ai,
  input  logic                   flush,
  output logic                   valid_raw,
  output logic [3:0]             raw,
  output logic                   valid_o,
  output logic [WORD_W-1:0]      writer_data,
  output logic [CNT_W-1:0]       fill_bits,
  output logic [1:0]             mode_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [1:0]        mode_lat_q, mode_lat_d;
  logic              valid_raw_q, valid_raw_d;
  logic [3:0]        raw_q, raw_d;
  logic              valid_o_q, valid_o_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [1:0]        mode_o_q, mode_o_d;

  logic [1:0]        mode_eff_s;
  logic [2:0]        bits_s;
  logic [3:0]        raw_s;
  logic              take_s;
  logic              emit_s;
  logic [WORD_W-1:0] sr_ins_s;
  logic [CNT_W-1:0]  cnt_ins_s;

  iqdemap_slicer #(
    .IQ_W    (IQ_W),
    .QAM_THR (QAM_THR)
  ) u_slicer (
    .ar   (ar),
    .ai   (ai),
    .mode (mode_eff_s),
    .raw  (raw_s)
  );

  // Next-state: mode latch, bit insertion, full/flush emission.
  always_comb begin
    mode_eff_s  = (cnt_q == {CNT_W{1'b0}}) ? mode : mode_lat_q;
    bits_s      = bits_per_mode(mode_eff_s);
    take_s      = ce & valid_i;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    mode_lat_d  = mode_lat_q;
    valid_raw_d = 1'b0;
    raw_d       = raw_q;
    valid_o_d   = 1'b0;
    wd_d        = wd_q;
    fill_d      = fill_q;
    mode_o_d    = mode_o_q;
    sr_ins_s    = sr_q;
    cnt_ins_s   = cnt_q;
    emit_s      = 1'b0;
    if (take_s) begin
      sr_ins_s    = (sr_q << bits_s) | {{(WORD_W-4){1'b0}}, raw_s};
      cnt_ins_s   = cnt_q + CNT_W'(bits_s);
      valid_raw_d = 1'b1;
      raw_d       = raw_s;
      mode_lat_d  = mode_eff_s;
    end else begin
      sr_ins_s    = sr_q;
      cnt_ins_s   = cnt_q;
    end
    if (ce) begin
      emit_s = (cnt_ins_s == FULL_CNT) ||
               (flush && (cnt_ins_s != {CNT_W{1'b0}}));
      if (emit_s) begin
        // Left-align the collected bits; the shift is zero for a full word.
        valid_o_d = 1'b1;
        wd_d      = sr_ins_s << (FULL_CNT - cnt_ins_s);
        fill_d    = cnt_ins_s;
        mode_o_d  = mode_eff_s;
        cnt_d     = {CNT_W{1'b0}};
        sr_d      = {WORD_W{1'b0}};
      end else begin
        cnt_d     = cnt_ins_s;
        sr_d      = sr_ins_s;
      end
    end else begin
      emit_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      sr_q        <= {WORD_W{1'b0}};
      mode_lat_q  <= 2'd0;
      valid_raw_q <= 1'b0;
      raw_q       <= 4'd0;
      valid_o_q   <= 1'b0;
      wd_q        <= {WORD_W{1'b0}};
      fill_q      <= {CNT_W{1'b0}};
      mode_o_q    <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      mode_lat_q  <= mode_lat_d;
      valid_raw_q <= valid_raw_d;
      raw_q       <= raw_d;
      valid_o_q   <= valid_o_d;
      wd_q        <= wd_d;
      fill_q      <= fill_d;
      mode_o_q    <= mode_o_d;
    end
  end

  assign valid_raw   = valid_raw_q;
  assign raw         = raw_q;
  assign valid_o     = valid_o_q;
  assign writer_data = wd_q;
  assign fill_bits   = fill_q;
  assign mode_o      = mode_o_q;

endmodule
